// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if
// Bundles the requester-side bus of the shared register arbiter.
//   req     : per-requester write request (level)
//   wdata   : packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt     : registered one-hot grant, or all-zero
//   gnt_id  : index of the granted requester (sticky when gnt is 0)
//   a_q     : shared register contents
//   a_valid : one-cycle pulse after each commit into a_q
// master = requester side, slave = arbiter side.
interface shared_reg_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [IDW-1:0]         gnt_id;
  logic [WIDTH-1:0]       a_q;
  logic                   a_valid;

  modport master (output req, wdata, input gnt, gnt_id, a_q, a_valid);
  modport slave  (input req, wdata, output gnt, gnt_id, a_q, a_valid);
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters.
// The owner may commit for up to MAX_HOLD consecutive cycles, after which the
// grant rotates to the next requester without a bubble.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : shared_reg_arbiter_if slave modport (req/wdata in, gnt/gnt_id/a_q/a_valid out)
module shared_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_reg_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [N_REQ-1:0] gnt_q;
  logic [IDW-1:0]   gnt_id_q;
  logic [IDW-1:0]   last;
  logic [HW-1:0]    hold_cnt;
  logic [WIDTH-1:0] a_q_q;
  logic             a_valid_q;

  logic [IDW-1:0]   pick_base;
  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] pick_onehot;
  logic             owner_req;
  logic [WIDTH-1:0] owner_data;

  // While busy the owner is about to become "last" on release, so the scan
  // starts just after it; in IDLE it starts after the stored last winner.
  assign pick_base = (state == BUSY) ? gnt_id_q : last;

  // Round-robin scan: first the indices above the base in ascending order,
  // then wrap to 0..base, so the base itself is chosen only when it alone
  // is requesting.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && bus.req[i] && (IDW'(i) > pick_base)) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && bus.req[i] && (IDW'(i) <= pick_base)) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(i);
      end
    end
  end

  // Decode the pick and select the current owner's request and data.
  always_comb begin
    pick_onehot = '0;
    owner_req   = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_onehot[i] = (pick_idx == IDW'(i));
      if (gnt_id_q == IDW'(i)) begin
        owner_req  = bus.req[i];
        owner_data = bus.wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Arbiter FSM. In BUSY the owner commits while it keeps requesting; the
  // grant is released when the burst is exhausted or the owner withdraws,
  // and the next owner is picked in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last      <= IDW'(N_REQ - 1);
      hold_cnt  <= '0;
      a_q_q     <= '0;
      a_valid_q <= 1'b0;
    end else begin
      a_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt_q    <= pick_onehot;
            gnt_id_q <= pick_idx;
            hold_cnt <= HW'(1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (owner_req) begin
            a_q_q     <= owner_data;
            a_valid_q <= 1'b1;
          end
          if (owner_req && (hold_cnt < HOLD_MAX)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end else begin
            last <= gnt_id_q;
            if (pick_found) begin
              gnt_q    <= pick_onehot;
              gnt_id_q <= pick_idx;
              hold_cnt <= HW'(1);
            end else begin
              gnt_q    <= '0;
              hold_cnt <= '0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.a_q     = a_q_q;
  assign bus.a_valid = a_valid_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter
// Directed bench for shared_reg_arbiter: one instance with MAX_HOLD=4 and a
// second with MAX_HOLD=1. Inputs change and outputs are sampled on the
// falling edge, so each sample shows the result of the preceding rising edge.
module tb_shared_reg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  shared_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus4 ();
  shared_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus1 ();

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    rst        = 1'b1;
    bus4.req   = '0;
    bus1.req   = '0;
    bus4.wdata = '0;
    bus1.wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset values, then an idle bus for five cycles.
  task automatic test_reset();
    do_reset();
    vectors++; if (bus4.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_gnt got %b want 0000", bus4.gnt); end
    vectors++; if (bus4.gnt_id !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_gnt_id got %0d want 0", bus4.gnt_id); end
    vectors++; if (bus4.a_q !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_a_q got %h want 00", bus4.a_q); end
    vectors++; if (bus4.a_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_a_valid got %b want 0", bus4.a_valid); end
    vectors++; if (bus1.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_gnt_h1 got %b want 0000", bus1.gnt); end
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      vectors++; if (bus4.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL idle_gnt cyc %0d got %b want 0000", n, bus4.gnt); end
      vectors++; if (bus4.a_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_a_valid cyc %0d got %b want 0", n, bus4.a_valid); end
      vectors++; if (bus4.a_q !== 8'h00) begin miscompares++; $display("[TB] FAIL idle_a_q cyc %0d got %h want 00", n, bus4.a_q); end
    end
  endtask

  // All four requesting: owners 0,1,2,3 for four commits each, then back to 0.
  task automatic test_round_robin();
    int         owner;
    logic [3:0] exp_gnt;
    logic [7:0] exp_aq;
    do_reset();
    bus4.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus4.req   = 4'b1111;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      owner   = ((n - 1) / 4) % 4;
      exp_gnt = 4'b0001 << owner;
      vectors++; if (bus4.gnt !== exp_gnt) begin miscompares++; $display("[TB] FAIL rr_gnt cyc %0d got %b want %b", n, bus4.gnt, exp_gnt); end
      vectors++; if (bus4.gnt_id !== 2'(owner)) begin miscompares++; $display("[TB] FAIL rr_gnt_id cyc %0d got %0d want %0d", n, bus4.gnt_id, owner); end
      vectors++; if (bus4.a_valid !== (n >= 2)) begin miscompares++; $display("[TB] FAIL rr_a_valid cyc %0d got %b want %b", n, bus4.a_valid, (n >= 2)); end
      if (n >= 2) begin
        exp_aq = 8'(8'h11 * ((((n - 2) / 4) % 4) + 1));
        vectors++; if (bus4.a_q !== exp_aq) begin miscompares++; $display("[TB] FAIL rr_a_q cyc %0d got %h want %h", n, bus4.a_q, exp_aq); end
      end
    end
  endtask

  // A sole requester keeps the grant across burst boundaries with no bubble.
  task automatic test_sole_requester();
    do_reset();
    bus4.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus4.req   = 4'b0010;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      vectors++; if (bus4.gnt !== 4'b0010) begin miscompares++; $display("[TB] FAIL sole_gnt cyc %0d got %b want 0010", n, bus4.gnt); end
      vectors++; if (bus4.a_valid !== (n >= 2)) begin miscompares++; $display("[TB] FAIL sole_a_valid cyc %0d got %b want %b", n, bus4.a_valid, (n >= 2)); end
      if (n >= 2) begin
        vectors++; if (bus4.a_q !== 8'h22) begin miscompares++; $display("[TB] FAIL sole_a_q cyc %0d got %h want 22", n, bus4.a_q); end
      end
    end
  endtask

  // Owner 2 withdraws after two commits; rotation continues at 3, not 0.
  task automatic test_withdraw();
    do_reset();
    bus4.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus4.req   = 4'b0100;
    @(negedge clk);
    vectors++; if (bus4.gnt !== 4'b0100) begin miscompares++; $display("[TB] FAIL wd_first_gnt got %b want 0100", bus4.gnt); end
    bus4.req = 4'b1101;
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      vectors++; if (bus4.gnt !== 4'b0100) begin miscompares++; $display("[TB] FAIL wd_hold_gnt commit %0d got %b want 0100", n, bus4.gnt); end
      vectors++; if (bus4.a_q !== 8'h33) begin miscompares++; $display("[TB] FAIL wd_hold_a_q commit %0d got %h want 33", n, bus4.a_q); end
      vectors++; if (bus4.a_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wd_hold_a_valid commit %0d got %b want 1", n, bus4.a_valid); end
    end
    bus4.req = 4'b1001;
    @(negedge clk);
    vectors++; if (bus4.gnt !== 4'b1000) begin miscompares++; $display("[TB] FAIL wd_next_gnt got %b want 1000", bus4.gnt); end
    vectors++; if (bus4.gnt_id !== 2'd3) begin miscompares++; $display("[TB] FAIL wd_next_gnt_id got %0d want 3", bus4.gnt_id); end
    vectors++; if (bus4.a_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wd_drop_a_valid got %b want 0", bus4.a_valid); end
    vectors++; if (bus4.a_q !== 8'h33) begin miscompares++; $display("[TB] FAIL wd_drop_a_q got %h want 33", bus4.a_q); end
    @(negedge clk);
    vectors++; if (bus4.a_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wd_resume_a_valid got %b want 1", bus4.a_valid); end
    vectors++; if (bus4.a_q !== 8'h44) begin miscompares++; $display("[TB] FAIL wd_resume_a_q got %h want 44", bus4.a_q); end
  endtask

  // Reset in the middle of owner 1's burst clears everything immediately.
  task automatic test_mid_burst_reset();
    do_reset();
    bus4.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus4.req   = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus4.a_q !== 8'h22) begin miscompares++; $display("[TB] FAIL mbr_pre_a_q got %h want 22", bus4.a_q); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (bus4.gnt !== 4'b0000) begin miscompares++; $display("[TB] FAIL mbr_gnt got %b want 0000", bus4.gnt); end
    vectors++; if (bus4.gnt_id !== 2'd0) begin miscompares++; $display("[TB] FAIL mbr_gnt_id got %0d want 0", bus4.gnt_id); end
    vectors++; if (bus4.a_q !== 8'h00) begin miscompares++; $display("[TB] FAIL mbr_a_q got %h want 00", bus4.a_q); end
    vectors++; if (bus4.a_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mbr_a_valid got %b want 0", bus4.a_valid); end
    rst      = 1'b0;
    bus4.req = 4'b1010;
    @(negedge clk);
    vectors++; if (bus4.gnt !== 4'b0010) begin miscompares++; $display("[TB] FAIL mbr_regrant_gnt got %b want 0010", bus4.gnt); end
    vectors++; if (bus4.gnt_id !== 2'd1) begin miscompares++; $display("[TB] FAIL mbr_regrant_gnt_id got %0d want 1", bus4.gnt_id); end
  endtask

  // MAX_HOLD=1: requesters 0 and 3 alternate every cycle.
  task automatic test_hold_one();
    logic [3:0] exp_gnt;
    logic [7:0] exp_aq;
    do_reset();
    bus1.wdata = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    bus1.req   = 4'b1001;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      exp_gnt = (n % 2 == 1) ? 4'b0001 : 4'b1000;
      vectors++; if (bus1.gnt !== exp_gnt) begin miscompares++; $display("[TB] FAIL h1_gnt cyc %0d got %b want %b", n, bus1.gnt, exp_gnt); end
      if (n >= 2) begin
        exp_aq = (n % 2 == 0) ? 8'hA1 : 8'hD4;
        vectors++; if (bus1.a_q !== exp_aq) begin miscompares++; $display("[TB] FAIL h1_a_q cyc %0d got %h want %h", n, bus1.a_q, exp_aq); end
        vectors++; if (bus1.a_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL h1_a_valid cyc %0d got %b want 1", n, bus1.a_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_sole_requester();
    test_withdraw();
    test_mid_burst_reset();
    test_hold_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
